input_conditioner: RTL and testbench
====================================

Name: input_conditioner

Overview:
- Front-end stage that feeds the game core (`Main`).
- Takes the raw, asynchronous, bouncy player buttons `izq`, `der` and `fire`, then synchronizes and debounces them.
- Converts them into a clamped horizontal crosshair position and a single-cycle, rate-limited `shot` pulse.
- The core consumes these directly for hit detection and crosshair rendering.

Parameters:
- DEBOUNCE_CYCLES, 500000, consecutive stable cycles required to accept a button level (10 ms at 50 MHz).
- REPEAT_CYCLES, 1250000, auto-repeat interval while a direction button is held.
- STEP, 4, pixels moved per move event.
- X_MIN, 0, minimum crosshair_x.
- X_MAX, 639, maximum crosshair_x.
- X_START, 320, crosshair_x after reset.
- FIRE_COOLDOWN, 12500000, cycles after a shot during which fire is ignored.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  asynchronous, active-low reset; 0 = reset.
- izq  input  1  raw left button, asynchronous, active-high.
- der  input  1  raw right button, asynchronous, active-high.
- fire  input  1  raw fire button, asynchronous, active-high.
- crosshair_x  output  10  current crosshair column, registered.
- shot  output  1  one-cycle fire pulse, registered.
- fire_busy  output  1  high while a shot or cooldown is in progress, registered.

Behaviour:
- Reset (reset=0, asynchronous):
  - crosshair_x=X_START, shot=0, fire_busy=0.
  - Synchronizers, debounced levels and all counters cleared to 0; fire FSM goes to IDLE.
  - Asserting reset mid-movement or mid-cooldown aborts immediately.
  - After release, a button already held must re-debounce before it takes effect.
- Synchronizer: two flops per button.
- Debouncer, one per button:
  - Counter clears whenever the synced value equals the debounced value; otherwise it increments.
  - When the counter equals DEBOUNCE_CYCLES-1 and the values still mismatch, the debounced value takes the synced value and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES cycles never changes the debounced value.
- Edge detect: a registered copy of each debounced level gives press = debounced & ~prev.
- Movement:
  - Only izq debounced high: on its press cycle, crosshair_x -= STEP.
    - Then the repeat counter runs; every REPEAT_CYCLES cycles while still held, another -= STEP.
  - Only der debounced high: same behaviour with +=.
  - Both high, or neither: no movement, repeat counter held at 0.
    - Releasing one of the two restarts the counter; the first repeat move comes REPEAT_CYCLES later. No immediate move occurs on release.
  - Saturation: a decrement below X_MIN yields X_MIN; an increment above X_MAX yields X_MAX.
    - Compute in 11 bits so there is no wrap-around.
- Fire FSM, states IDLE, SHOT, COOLDOWN:
  - IDLE: fire press -> SHOT.
  - SHOT: shot=1 for exactly one cycle, fire_busy=1 -> COOLDOWN.
  - COOLDOWN: fire_busy=1; counts FIRE_COOLDOWN cycles -> IDLE.
    - Presses during SHOT or COOLDOWN are dropped, not queued.
    - Holding fire through cooldown never produces a second shot; a new press edge is required.
- Latency: a raw level held stable from sampling edge 1 gives a debounced change at edge DEBOUNCE_CYCLES+2.
  - shot and the first crosshair_x update are visible after edge DEBOUNCE_CYCLES+3.
- Fire and movement are independent; simultaneous fire and direction presses are both honoured in the same cycle.

Test Plan (DEBOUNCE_CYCLES=4, REPEAT_CYCLES=8, STEP=4, FIRE_COOLDOWN=10, X_MIN=0, X_MAX=639, X_START=320):
- Pulse reset low for 2 cycles, inputs 0 -> crosshair_x=320, shot=0, fire_busy=0. Assert reset asynchronously between edges -> outputs clear without a clock edge.
- Hold der high from edge 1 for 20 cycles -> crosshair_x=324 after edge 7, then 328 after edge 15. Toggle der every 2 cycles instead -> crosshair_x stays 320.
- Hold fire high from edge 1 -> shot=1 only in the cycle after edge 7; fire_busy=1 for 11 cycles (SHOT + 10). With fire still held, no further shot.
- Release fire, re-press during cooldown -> no shot. Press again after fire_busy falls -> exactly one shot.
- Hold izq with X_START=2 -> crosshair_x=0 and stays 0. Hold der near the top -> saturates at 639, never wraps.
- Hold izq and der together -> crosshair_x unchanged. Release der -> the first left move occurs 8 cycles later. Assert reset mid-hold -> crosshair_x=320 and 4 debounce cycles are needed again.

Source files
------------

// File: rtl/input_conditioner_if.sv
// Button inputs and conditioned outputs exchanged between the raw player
// controls (master side) and the input conditioner (slave side).
interface input_conditioner_if;
    logic       izq;
    logic       der;
    logic       fire;
    logic [9:0] crosshair_x;
    logic       shot;
    logic       fire_busy;

    modport master (
        output izq, der, fire,
        input  crosshair_x, shot, fire_busy
    );

    modport slave (
        input  izq, der, fire,
        output crosshair_x, shot, fire_busy
    );
endinterface

// File: rtl/input_conditioner.sv
// Synchronizes and debounces the player buttons, then turns them into a
// clamped crosshair column and a rate-limited single-cycle shot pulse.
module input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_CYCLES   = 1250000,
    parameter int STEP            = 4,
    parameter int X_MIN           = 0,
    parameter int X_MAX           = 639,
    parameter int X_START         = 320,
    parameter int FIRE_COOLDOWN   = 12500000
) (
    input  logic                 clk,
    input  logic                 reset,
    input_conditioner_if.slave   bus
);
    localparam int DB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int RPT_W = (REPEAT_CYCLES > 1)   ? $clog2(REPEAT_CYCLES)   : 1;
    localparam int CD_W  = (FIRE_COOLDOWN > 1)   ? $clog2(FIRE_COOLDOWN)   : 1;

    localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [RPT_W-1:0] RPT_LAST = RPT_W'(REPEAT_CYCLES - 1);
    localparam logic [CD_W-1:0]  CD_LAST  = CD_W'(FIRE_COOLDOWN - 1);

    localparam logic [10:0] STEP_X     = 11'(STEP);
    localparam logic [10:0] X_MIN_X    = 11'(X_MIN);
    localparam logic [10:0] X_MAX_X    = 11'(X_MAX);
    localparam logic [10:0] LEFT_FLOOR = 11'(X_MIN + STEP);
    localparam logic [9:0]  X_START_V  = 10'(X_START);

    // Bit 0 = izq, bit 1 = der, bit 2 = fire.
    logic [2:0] btn_raw;
    logic [2:0] deb_level;
    logic [2:0] deb_prev_level;
    logic [2:0] press;

    assign btn_raw = {bus.fire, bus.der, bus.izq};
    assign press   = deb_level & ~deb_prev_level;

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_btn
            logic            sync1_reg;
            logic            sync2_reg;
            logic            deb_reg;
            logic            prev_reg;
            logic [DB_W-1:0] db_cnt_reg;

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    sync1_reg  <= 1'b0;
                    sync2_reg  <= 1'b0;
                    deb_reg    <= 1'b0;
                    prev_reg   <= 1'b0;
                    db_cnt_reg <= '0;
                end else begin
                    sync1_reg <= btn_raw[gi];
                    sync2_reg <= sync1_reg;
                    prev_reg  <= deb_reg;
                    if (sync2_reg == deb_reg) begin
                        db_cnt_reg <= '0;
                    end else if (db_cnt_reg == DB_LAST) begin
                        deb_reg    <= sync2_reg;
                        db_cnt_reg <= '0;
                    end else begin
                        db_cnt_reg <= db_cnt_reg + DB_W'(1);
                    end
                end
            end

            assign deb_level[gi]      = deb_reg;
            assign deb_prev_level[gi] = prev_reg;
        end
    endgenerate

    // Movement: exactly one direction held moves on press, then auto-repeats.
    logic             left_only;
    logic             right_only;
    logic             do_move;
    logic [9:0]       x_reg;
    logic [9:0]       x_next;
    logic [10:0]      x_wide;
    logic [10:0]      x_calc;
    logic [RPT_W-1:0] rpt_cnt_reg;
    logic [RPT_W-1:0] rpt_cnt_next;

    assign left_only  = deb_level[0] & ~deb_level[1];
    assign right_only = deb_level[1] & ~deb_level[0];
    assign x_wide     = {1'b0, x_reg};

    always_comb begin
        rpt_cnt_next = '0;
        x_next       = x_reg;
        do_move      = 1'b0;
        x_calc       = x_wide;
        if (left_only || right_only) begin
            if ((left_only && press[0]) || (right_only && press[1])) begin
                do_move = 1'b1;
            end else if (rpt_cnt_reg == RPT_LAST) begin
                do_move = 1'b1;
            end else begin
                rpt_cnt_next = rpt_cnt_reg + RPT_W'(1);
            end
        end
        if (do_move) begin
            // Eleven-bit arithmetic keeps the clamp free of wrap-around.
            if (left_only) begin
                x_calc = (x_wide < LEFT_FLOOR) ? X_MIN_X : (x_wide - STEP_X);
            end else begin
                x_calc = x_wide + STEP_X;
                if (x_calc > X_MAX_X) begin
                    x_calc = X_MAX_X;
                end
            end
            x_next = x_calc[9:0];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            x_reg       <= X_START_V;
            rpt_cnt_reg <= '0;
        end else begin
            x_reg       <= x_next;
            rpt_cnt_reg <= rpt_cnt_next;
        end
    end

    // Fire FSM: presses outside IDLE are dropped, never queued.
    typedef enum logic [1:0] {IDLE, SHOT, COOLDOWN} fire_state_t;

    fire_state_t     state_reg;
    fire_state_t     state_next;
    logic [CD_W-1:0] cd_cnt_reg;
    logic [CD_W-1:0] cd_cnt_next;
    logic            shot_reg;
    logic            busy_reg;

    always_comb begin
        state_next  = state_reg;
        cd_cnt_next = '0;
        case (state_reg)
            IDLE: begin
                if (press[2]) begin
                    state_next = SHOT;
                end
            end
            SHOT: begin
                state_next = COOLDOWN;
            end
            COOLDOWN: begin
                if (cd_cnt_reg == CD_LAST) begin
                    state_next = IDLE;
                end else begin
                    cd_cnt_next = cd_cnt_reg + CD_W'(1);
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg  <= IDLE;
            cd_cnt_reg <= '0;
            shot_reg   <= 1'b0;
            busy_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            cd_cnt_reg <= cd_cnt_next;
            shot_reg   <= (state_next == SHOT);
            busy_reg   <= (state_next != IDLE);
        end
    end

    assign bus.crosshair_x = x_reg;
    assign bus.shot        = shot_reg;
    assign bus.fire_busy   = busy_reg;
endmodule

// File: tb/tb_input_conditioner.sv
// Randomized scoreboard bench for input_conditioner with a timing-rule
// reference model of debounce, auto-repeat movement and fire cooldown.
module tb_input_conditioner;
    localparam int DB     = 4;
    localparam int RPT    = 8;
    localparam int STP    = 4;
    localparam int CD     = 10;
    localparam int XMIN   = 0;
    localparam int XMAX   = 639;
    localparam int XSTART = 320;

    logic clk = 1'b0;
    logic reset;

    input_conditioner_if ic_if ();

    input_conditioner #(
        .DEBOUNCE_CYCLES (DB),
        .REPEAT_CYCLES   (RPT),
        .STEP            (STP),
        .X_MIN           (XMIN),
        .X_MAX           (XMAX),
        .X_START         (XSTART),
        .FIRE_COOLDOWN   (CD)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ic_if)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [9:0] x;
        logic       shot;
        logic       busy;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model state: edges counted from reset release.
    bit [2:0] raw_hist[$];
    int       m_t;
    bit [2:0] m_deb;
    bit [2:0] m_deb_prev;
    int       m_x;
    int       m_last_shot;
    int       m_mode;       // 0 none, 1 left only, 2 right only
    int       m_epoch;      // edge at which current mode began
    bit       m_epoch_press;

    function automatic bit [2:0] raw_at(int k);
        if (k < 1) return 3'b000;
        return raw_hist[k-1];
    endfunction

    function automatic int mode_of(bit [2:0] d);
        if (d[0] && !d[1]) return 1;
        if (d[1] && !d[0]) return 2;
        return 0;
    endfunction

    function automatic exp_t reset_exp();
        exp_t e;
        e.x    = 10'(XSTART);
        e.shot = 1'b0;
        e.busy = 1'b0;
        return e;
    endfunction

    task automatic model_reset();
        m_t           = 0;
        raw_hist.delete();
        m_deb         = 3'b000;
        m_deb_prev    = 3'b000;
        m_x           = XSTART;
        m_last_shot   = -1000;
        m_mode        = 0;
        m_epoch       = 0;
        m_epoch_press = 1'b0;
    endtask

    task automatic model_edge(bit [2:0] raw_now);
        exp_t     e;
        bit [2:0] rose;
        bit [2:0] new_deb;
        bit       shot_now;
        bit       move;
        int       elapsed;
        int       new_mode;
        if (!reset) begin
            model_reset();
            exp_q.push_back(reset_exp());
            return;
        end
        m_t++;
        raw_hist.push_back(raw_now);
        rose = m_deb & ~m_deb_prev;

        // A press is honoured only once the previous shot's busy window is over.
        shot_now = rose[2] && ((m_t - 1) >= (m_last_shot + CD + 1));
        if (shot_now) m_last_shot = m_t;

        if (m_mode != 0) begin
            elapsed = m_t - m_epoch;
            move = m_epoch_press ? (((elapsed - 1) % RPT) == 0) : ((elapsed % RPT) == 0);
            if (move) begin
                if (m_mode == 1) m_x = (m_x - STP < XMIN) ? XMIN : m_x - STP;
                else             m_x = (m_x + STP > XMAX) ? XMAX : m_x + STP;
            end
        end

        // Debounced level follows the raw level once DB consecutive samples agree.
        new_deb = m_deb;
        for (int b = 0; b < 3; b++) begin
            bit v;
            bit same;
            bit [2:0] smp;
            smp  = raw_at(m_t - 2);
            v    = smp[b];
            same = 1'b1;
            for (int k = 2; k <= DB + 1; k++) begin
                smp = raw_at(m_t - k);
                if (smp[b] != v) same = 1'b0;
            end
            if (same && (v != m_deb[b])) new_deb[b] = v;
        end
        m_deb_prev = m_deb;
        m_deb      = new_deb;

        new_mode = mode_of(m_deb);
        if (new_mode != m_mode) begin
            rose          = m_deb & ~m_deb_prev;
            m_epoch       = m_t;
            m_epoch_press = (new_mode == 1) ? rose[0] : (new_mode == 2) ? rose[1] : 1'b0;
            m_mode        = new_mode;
        end

        e.x    = 10'(m_x);
        e.shot = shot_now;
        e.busy = (m_t <= m_last_shot + CD);
        exp_q.push_back(e);
    endtask

    task automatic check(string name, int act, int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, req);
        end
    endtask

    // Monitor: every cycle the DUT presents a new output set.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check("crosshair_x", int'(ic_if.crosshair_x), int'(e.x));
            check("shot",        int'(ic_if.shot),        int'(e.shot));
            check("fire_busy",   int'(ic_if.fire_busy),   int'(e.busy));
        end
    end

    task automatic step(bit [2:0] lvl);
        ic_if.izq  = lvl[0];
        ic_if.der  = lvl[1];
        ic_if.fire = lvl[2];
        @(posedge clk);
        model_edge(lvl);
        #1;
    endtask

    task automatic hold(bit [2:0] lvl, int n);
        for (int i = 0; i < n; i++) step(lvl);
    endtask

    // Called one time unit after an edge; reset drops between edges.
    task automatic async_reset(bit [2:0] lvl);
        #1;
        reset = 1'b0;
        #1;
        model_reset();
        exp_q[exp_q.size()-1] = reset_exp();
        hold(lvl, 2);
        #2;
        reset = 1'b1;
    endtask

    initial begin
        #2_000_000;
        errors++;
        $display("FAIL watchdog: got timeout, expected end of stimulus");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        bit [2:0] lvl;
        int       len;
        reset      = 1'b0;
        ic_if.izq  = 1'b0;
        ic_if.der  = 1'b0;
        ic_if.fire = 1'b0;
        model_reset();
        hold(3'b000, 2);
        #2;
        reset = 1'b1;

        // Right move on press, repeat, then a bouncing right button.
        hold(3'b010, 20);
        hold(3'b000, 12);
        for (int i = 0; i < 6; i++) begin
            hold(3'b010, 2);
            hold(3'b000, 2);
        end

        // Fire held, then re-presses inside and after cooldown.
        hold(3'b100, 40);
        hold(3'b000, 8);
        hold(3'b100, 8);
        hold(3'b000, 8);
        hold(3'b100, 8);
        hold(3'b000, 20);

        // Saturation at both ends.
        hold(3'b001, 700);
        check("floor_x", int'(ic_if.crosshair_x), XMIN);
        hold(3'b000, 10);
        hold(3'b010, 1400);
        check("ceiling_x", int'(ic_if.crosshair_x), XMAX);

        // Both held, release one, then reset mid-hold.
        hold(3'b011, 30);
        hold(3'b001, 30);
        async_reset(3'b001);
        check("reset_x", int'(ic_if.crosshair_x), XSTART);
        hold(3'b001, 30);
        hold(3'b000, 10);

        for (int seg = 0; seg < 150; seg++) begin
            lvl = 3'($urandom_range(0, 7));
            len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3))
                                              : int'($urandom_range(4, 40));
            hold(lvl, len);
            if ($urandom_range(0, 40) == 0) async_reset(lvl);
        end

        hold(3'b000, 2);
        #10;
        check("queue_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
